// File: rtl/mu0_bus_pkg.sv
// Shared MU0 memory-bus types and constants.
package mu0_bus_pkg;
  localparam int DATA_W = 16;
  localparam logic [11:0] OUT_ADDR_DEF   = 12'hFFF;
  localparam logic [11:0] OUTRB_ADDR_DEF = 12'hFFE;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;
endpackage

// File: rtl/mu0_mem_responder_if.sv
// MU0 memory bus: requester drives Rd/Wr/Addr/WData, responder returns data and status.
interface mu0_mem_responder_if #(
  parameter int ADDR_W = 12
);
  logic                          Rd;
  logic                          Wr;
  logic [ADDR_W-1:0]             Addr;
  logic [mu0_bus_pkg::DATA_W-1:0] WData;
  logic [mu0_bus_pkg::DATA_W-1:0] RData;
  logic                          Ack;
  logic                          Busy;
  logic                          Err;

  modport master (output Rd, Wr, Addr, WData, input RData, Ack, Busy, Err);
  modport slave  (input Rd, Wr, Addr, WData, output RData, Ack, Busy, Err);
endinterface

// File: rtl/mu0_mem_array.sv
// Single-port synchronous word store: write-enable, registered read, no reset.
module mu0_mem_array #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mu0_mem_responder.sv
// MU0 memory responder: wait-stated store access plus memory-mapped In/Out ports
// at the top of the address space.
module mu0_mem_responder
  import mu0_bus_pkg::*;
#(
  parameter int unsigned       WAIT_STATES = 2,
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] OUT_ADDR    = ADDR_W'(OUT_ADDR_DEF),
  parameter logic [ADDR_W-1:0] OUTRB_ADDR  = ADDR_W'(OUTRB_ADDR_DEF)
) (
  input  logic                Clk,
  input  logic                nReset,
  mu0_mem_responder_if.slave  bus,
  input  logic [DATA_W-1:0]   InPort,
  output logic [DATA_W-1:0]   OutPort
);
  localparam int unsigned CNT_INIT = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;
  localparam logic [3:0]  CNT_LOAD = CNT_INIT[3:0];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] io_rd_q;
  logic              rsel_io_q;

  logic              req_one, req_both, accept, commit;
  op_e               cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              hit_out, hit_rb, mem_we, mem_re;
  logic [DATA_W-1:0] mem_rdata;

  assign req_one  = bus.Rd ^ bus.Wr;
  assign req_both = bus.Rd & bus.Wr;
  assign accept   = (state_q == IDLE) && req_one;

  // With zero wait states the commit edge is the accepting edge, so the
  // request is taken straight from the bus; otherwise from the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_op    = bus.Wr ? OP_WR : OP_RD;
      cur_addr  = bus.Addr;
      cur_wdata = bus.WData;
    end else begin
      cur_op    = op_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_one) begin
          if (WAIT_STATES == 0) begin
            state_d = ACK;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hit_out = (cur_addr == OUT_ADDR);
  assign hit_rb  = (cur_addr == OUTRB_ADDR);
  assign mem_we  = commit && (cur_op == OP_WR) && !hit_out && !hit_rb;
  assign mem_re  = commit && (cur_op == OP_RD) && !hit_out && !hit_rb;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      op_q      <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      out_q     <= '0;
      io_rd_q   <= '0;
      rsel_io_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= (state_q == IDLE) && req_both;
      if (accept) begin
        op_q    <= bus.Wr ? OP_WR : OP_RD;
        addr_q  <= bus.Addr;
        wdata_q <= bus.WData;
      end
      if (commit && (cur_op == OP_WR) && hit_out) out_q <= cur_wdata;
      // Port reads land in io_rd_q; store reads land in the array's own
      // output register. rsel_io_q remembers which one RData shows.
      if (commit && (cur_op == OP_RD)) begin
        rsel_io_q <= hit_out | hit_rb;
        if (hit_out)     io_rd_q <= InPort;
        else if (hit_rb) io_rd_q <= out_q;
      end
    end
  end

  mu0_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i   (Clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (cur_addr),
    .wdata_i (cur_wdata),
    .rdata_o (mem_rdata)
  );

  assign bus.RData = rsel_io_q ? io_rd_q : mem_rdata;
  assign bus.Ack   = (state_q == ACK);
  assign bus.Busy  = (state_q != IDLE);
  assign bus.Err   = err_q;
  assign OutPort   = out_q;
endmodule

// File: tb/tb_mu0_mem_responder.sv
// Bench for mu0_mem_responder: one instance with 2 wait states, one with 0,
// checked against a transaction-level model of store, OutPort and RData.
module tb_mu0_mem_responder;
  import mu0_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n_v, rd_v, wr_v;
  logic [1:0][11:0] addr_v;
  logic [1:0][15:0] wdata_v, inport_v;
  logic [1:0]       ack_v, busy_v, err_v;
  logic [1:0][15:0] rdata_v, outport_v;
  logic [15:0]      out0, out1;

  mu0_mem_responder_if #(.ADDR_W(12)) bus0 ();
  mu0_mem_responder_if #(.ADDR_W(12)) bus1 ();

  assign bus0.Rd = rd_v[0];  assign bus0.Wr = wr_v[0];
  assign bus0.Addr = addr_v[0];  assign bus0.WData = wdata_v[0];
  assign bus1.Rd = rd_v[1];  assign bus1.Wr = wr_v[1];
  assign bus1.Addr = addr_v[1];  assign bus1.WData = wdata_v[1];
  assign ack_v   = {bus1.Ack, bus0.Ack};
  assign busy_v  = {bus1.Busy, bus0.Busy};
  assign err_v   = {bus1.Err, bus0.Err};
  assign rdata_v = {bus1.RData, bus0.RData};
  assign outport_v = {out1, out0};

  mu0_mem_responder #(.WAIT_STATES(2)) u_ws2 (
    .Clk(clk), .nReset(rst_n_v[0]), .bus(bus0), .InPort(inport_v[0]), .OutPort(out0)
  );
  mu0_mem_responder #(.WAIT_STATES(0)) u_ws0 (
    .Clk(clk), .nReset(rst_n_v[1]), .bus(bus1), .InPort(inport_v[1]), .OutPort(out1)
  );

  // Reference model: store contents, output register, last read result.
  logic [15:0] m_mem [2][4096];
  logic [15:0] m_out [2];
  logic [15:0] m_rdata [2];
  logic [11:0] pool [2][6];

  int n_cmp = 0;
  int n_mis = 0;

  function automatic int ws_of(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(int k);
    chk($sformatf("rst_ack%0d", k),   16'(ack_v[k]),  16'h0);
    chk($sformatf("rst_err%0d", k),   16'(err_v[k]),  16'h0);
    chk($sformatf("rst_busy%0d", k),  16'(busy_v[k]), 16'h0);
    chk($sformatf("rst_rdata%0d", k), rdata_v[k],     16'h0000);
    chk($sformatf("rst_out%0d", k),   outport_v[k],   16'h0000);
  endtask

  // One request held until Ack; optionally left asserted after Ack.
  task automatic txn(int k, bit is_wr, logic [11:0] a, logic [15:0] d,
                     logic [15:0] inp, bit hold);
    int ws = ws_of(k);
    @(negedge clk);
    chk($sformatf("idle_busy%0d", k), 16'(busy_v[k]), 16'h0);
    chk($sformatf("idle_ack%0d", k),  16'(ack_v[k]),  16'h0);
    rd_v[k] = !is_wr; wr_v[k] = is_wr;
    addr_v[k] = a; wdata_v[k] = d; inport_v[k] = inp;
    for (int n = 1; n <= ws + 1; n++) begin
      @(negedge clk);
      chk($sformatf("busy%0d", k), 16'(busy_v[k]), 16'h1);
      chk($sformatf("ack%0d_c%0d", k, n), 16'(ack_v[k]), 16'(n == ws + 1));
      if (n <= ws) begin
        // Bus changes during WAIT must not affect the transaction.
        addr_v[k] = 12'($urandom); wdata_v[k] = 16'($urandom);
        rd_v[k] = 1'($urandom); wr_v[k] = 1'($urandom);
      end else begin
        if (is_wr) begin
          if (a == 12'hFFF)      m_out[k] = d;
          else if (a != 12'hFFE) m_mem[k][a] = d;
        end else begin
          if (a == 12'hFFF)      m_rdata[k] = inp;
          else if (a == 12'hFFE) m_rdata[k] = m_out[k];
          else                   m_rdata[k] = m_mem[k][a];
        end
        chk($sformatf("rdata%0d@%h", k, a), rdata_v[k], m_rdata[k]);
        chk($sformatf("outport%0d", k), outport_v[k], m_out[k]);
        if (hold) begin
          rd_v[k] = !is_wr; wr_v[k] = is_wr; addr_v[k] = a; wdata_v[k] = d;
        end else begin
          rd_v[k] = 1'b0; wr_v[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic err_req(int k, logic [11:0] a, logic [15:0] d);
    @(negedge clk);
    chk($sformatf("err_pre_busy%0d", k), 16'(busy_v[k]), 16'h0);
    rd_v[k] = 1'b1; wr_v[k] = 1'b1; addr_v[k] = a; wdata_v[k] = d;
    @(negedge clk);
    chk($sformatf("err_pulse%0d", k), 16'(err_v[k]),  16'h1);
    chk($sformatf("err_busy%0d", k),  16'(busy_v[k]), 16'h0);
    chk($sformatf("err_ack%0d", k),   16'(ack_v[k]),  16'h0);
    rd_v[k] = 1'b0; wr_v[k] = 1'b0;
    @(negedge clk);
    chk($sformatf("err_end%0d", k),   16'(err_v[k]),  16'h0);
    chk($sformatf("err_busy2_%0d", k), 16'(busy_v[k]), 16'h0);
  endtask

  // Write that is killed by reset while in WAIT (2-wait-state instance only).
  task automatic abort_wr(logic [11:0] a, logic [15:0] d);
    @(negedge clk);
    wr_v[0] = 1'b1; addr_v[0] = a; wdata_v[0] = d;
    @(negedge clk);
    chk("abort_busy", 16'(busy_v[0]), 16'h1);
    rst_n_v[0] = 1'b0; wr_v[0] = 1'b0;
    m_out[0] = 16'h0; m_rdata[0] = 16'h0;
    #1;
    check_reset(0);
    @(negedge clk);
    rst_n_v[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("abort_noack", 16'(ack_v[0]), 16'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n_v = 2'b00; rd_v = '0; wr_v = '0;
    addr_v = '0; wdata_v = '0; inport_v = '0;
    for (int k = 0; k < 2; k++) begin
      m_out[k] = 16'h0; m_rdata[k] = 16'h0;
    end
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    rst_n_v = 2'b11;

    // Directed, 2 wait states
    txn(0, 1, 12'h010, 16'h1234, 16'h0, 0);
    txn(0, 0, 12'h010, 16'h0, 16'h0, 0);
    txn(0, 1, 12'hFFF, 16'h00FF, 16'h0, 0);
    txn(0, 0, 12'hFFE, 16'h0, 16'h0, 0);
    txn(0, 0, 12'hFFF, 16'h0, 16'hA5A5, 0);
    txn(0, 1, 12'hFFE, 16'h7777, 16'h0, 0);
    txn(0, 0, 12'hFFE, 16'h0, 16'h0, 0);
    err_req(0, 12'h010, 16'hDEAD);
    txn(0, 1, 12'h020, 16'h1111, 16'h0, 0);
    abort_wr(12'h020, 16'hBEEF);
    txn(0, 0, 12'h020, 16'h0, 16'h0, 0);
    txn(0, 0, 12'h010, 16'h0, 16'h0, 0);

    // Directed, 0 wait states, including a read held through Ack
    txn(1, 1, 12'h010, 16'h1234, 16'h0, 0);
    txn(1, 0, 12'h010, 16'h0, 16'h0, 1);
    txn(1, 0, 12'h010, 16'h0, 16'h0, 0);
    txn(1, 0, 12'hFFF, 16'h0, 16'h5A5A, 0);
    err_req(1, 12'h010, 16'hDEAD);
    txn(1, 0, 12'h010, 16'h0, 16'h0, 0);

    // Randomized traffic over a small prewritten address pool plus the ports
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) begin
        pool[k][i] = 12'($urandom_range(0, 12'hFFD));
        txn(k, 1, pool[k][i], 16'($urandom), 16'h0, 0);
      end
      for (int i = 0; i < 150; i++) begin
        int r = $urandom_range(0, 19);
        bit is_wr = 1'($urandom);
        logic [11:0] a;
        logic [15:0] d = 16'($urandom);
        logic [15:0] inp = 16'($urandom);
        if (r == 0) begin
          err_req(k, pool[k][$urandom_range(0, 5)], d);
        end else begin
          if (r < 3)      a = 12'hFFF;
          else if (r < 5) a = 12'hFFE;
          else            a = pool[k][$urandom_range(0, 5)];
          if (!is_wr && $urandom_range(0, 3) == 0) begin
            txn(k, 0, a, d, inp, 1);
            txn(k, 0, a, d, inp, 0);
          end else begin
            txn(k, is_wr, a, d, inp, 0);
          end
        end
      end
    end

    @(negedge clk);
    chk("final_busy0", 16'(busy_v[0]), 16'h0);
    chk("final_busy1", 16'(busy_v[1]), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
